// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: MULT, MULTU, DIV, DIVU into HI/LO over DATA_SIZE+2 cycles.
// Optional feature macro MDU_MTHILO_EN adds idle-time HI/LO write ports (MTHI/MTLO path).
module mult_div_unit #(
    parameter int DATA_SIZE   = 32,
    parameter int MDU_OP_SIZE = 2
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [MDU_OP_SIZE-1:0] i_op,
    input  logic [DATA_SIZE-1:0]   i_A,
    input  logic [DATA_SIZE-1:0]   i_B,
`ifdef MDU_MTHILO_EN
    input  logic                   i_hi_we,
    input  logic                   i_lo_we,
    input  logic [DATA_SIZE-1:0]   i_wdata,
`endif
    output logic                   o_busy,
    output logic                   o_done,
    output logic [DATA_SIZE-1:0]   o_hi,
    output logic [DATA_SIZE-1:0]   o_lo,
    output logic [1:0]             o_dbg_state
);
    localparam int N  = DATA_SIZE;
    localparam int CW = $clog2(DATA_SIZE + 1);
    localparam logic [MDU_OP_SIZE-1:0] OP_MULT = MDU_OP_SIZE'(0);
    localparam logic [MDU_OP_SIZE-1:0] OP_DIV  = MDU_OP_SIZE'(2);
    localparam logic [MDU_OP_SIZE-1:0] OP_DIVU = MDU_OP_SIZE'(3);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    // Handshake: i_start is taken only in S_IDLE; o_busy is high from the edge after
    // acceptance until the edge that raises the one-cycle o_done and updates HI/LO.
    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic [2*N-1:0]  r_acc;
    logic [N-1:0]    r_operand;
    logic [N-1:0]    r_a_orig;
    logic            r_is_div;
    logic            r_sign_a;
    logic            r_sign_b;
    logic            r_busy;
    logic            r_done;
    logic [N-1:0]    r_hi;
    logic [N-1:0]    r_lo;

    logic            w_start_signed;
    logic            w_start_div;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [N-1:0]    w_a_mag;
    logic [N-1:0]    w_b_mag;
    logic [N:0]      w_mul_sum;
    logic [N:0]      w_div_shift;
    logic [N:0]      w_div_diff;
    logic            w_div_ok;
    logic            w_div_zero;
    logic [2*N-1:0]  w_prod;
    logic [N-1:0]    w_quo;
    logic [N-1:0]    w_rem;

    assign w_start_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
    assign w_start_div    = (i_op == OP_DIV) || (i_op == OP_DIVU);
    assign w_a_neg        = w_start_signed & i_A[N-1];
    assign w_b_neg        = w_start_signed & i_B[N-1];
    assign w_a_mag        = w_a_neg ? -i_A : i_A;
    assign w_b_mag        = w_b_neg ? -i_B : i_B;

    // Multiply: r_acc = {partial product, remaining multiplier bits}, shifted right each cycle.
    assign w_mul_sum   = {1'b0, r_acc[2*N-1:N]} + (r_acc[0] ? {1'b0, r_operand} : '0);

    // Divide: r_acc = {partial remainder, dividend bits becoming quotient bits}, shifted left.
    assign w_div_shift = r_acc[2*N-1:N-1];
    assign w_div_diff  = w_div_shift - {1'b0, r_operand};
    assign w_div_ok    = ~w_div_diff[N];
    assign w_div_zero  = (r_operand == '0);

    assign w_prod = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
    assign w_quo  = (r_sign_a ^ r_sign_b) ? -r_acc[N-1:0] : r_acc[N-1:0];
    assign w_rem  = r_sign_a ? -r_acc[2*N-1:N] : r_acc[2*N-1:N];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_acc     <= '0;
            r_operand <= '0;
            r_a_orig  <= '0;
            r_is_div  <= 1'b0;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
`ifdef MDU_MTHILO_EN
                    if (i_hi_we) r_hi <= i_wdata;
                    if (i_lo_we) r_lo <= i_wdata;
`endif
                    if (i_start) begin
                        r_is_div  <= w_start_div;
                        r_sign_a  <= w_a_neg;
                        r_sign_b  <= w_b_neg;
                        r_a_orig  <= i_A;
                        r_acc     <= {{N{1'b0}}, (w_start_div ? w_a_mag : w_b_mag)};
                        r_operand <= w_start_div ? w_b_mag : w_a_mag;
                        r_count   <= CW'(DATA_SIZE);
                        r_busy    <= 1'b1;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_is_div) begin
                        r_acc <= {(w_div_ok ? w_div_diff[N-1:0] : w_div_shift[N-1:0]),
                                  r_acc[N-2:0], w_div_ok};
                    end else begin
                        r_acc <= {w_mul_sum, r_acc[N-1:1]};
                    end
                    r_count <= r_count - 1'b1;
                    if (r_count == CW'(1)) r_state <= S_FINISH;
                end
                S_FINISH: begin
                    if (!r_is_div) begin
                        {r_hi, r_lo} <= w_prod;
                    end else if (w_div_zero) begin
                        r_hi <= r_a_orig;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_hi        = r_hi;
    assign o_lo        = r_lo;
    assign o_dbg_state = r_state;
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit in the EX stage, beside the single-cycle ALU. Executes MULT, MULTU, DIV and DIVU on the same rs/rt operands the ALU receives, over DATA_SIZE+2 cycles. Results go to the architectural HI/LO registers, which MFHI/MFLO read. Busy is exported so the hazard unit stalls the pipeline while an operation is in flight.

## Interface
- DATA_SIZE, 32: operand and HI/LO width (even, ≥4).
- MDU_OP_SIZE, 2: width of the operation code.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  request pulse; sampled only in IDLE.
- i_op  in  MDU_OP_SIZE  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
- i_A  in  DATA_SIZE  rs: multiplicand or dividend.
- i_B  in  DATA_SIZE  rt: multiplier or divisor.
- o_busy  out  1  high while an operation is in flight (stall request).
- o_done  out  1  one-cycle pulse when HI/LO have been updated.
- o_hi  out  DATA_SIZE  HI register.
- o_lo  out  DATA_SIZE  LO register.
- With MDU_MTHILO_EN only: i_hi_we in 1, i_lo_we in 1, i_wdata in DATA_SIZE (see Configuration).

## Operation
- FSM states: IDLE, RUN, FINISH.
- IDLE + i_start:
  - Latch the op and the operand magnitudes. Signed ops use |x|, and record the sign of each operand.
  - Clear the accumulator.
  - Load the iteration counter with DATA_SIZE.
  - Go to RUN.
- RUN, multiply: shift-add, one multiplier bit per cycle, 2·DATA_SIZE-bit product register.
- RUN, divide: restoring shift-subtract, one quotient bit per cycle.
- RUN: decrement the counter each cycle; go to FINISH when it reaches 0 (DATA_SIZE RUN cycles).
- FINISH: apply signs and write HI/LO, pulse o_done, return to IDLE.
- Multiply: {HI,LO} = full 2·DATA_SIZE-bit product. MULT negates the product if the operand signs differ.
- Divide: LO = quotient, HI = remainder.
  - DIV: quotient is negated if the operand signs differ.
  - DIV: remainder takes the sign of the dividend.
- Divide by zero (i_B = 0, DIV or DIVU): LO = all ones, HI = i_A unmodified. Same latency as any other op.
- DIV of the most-negative value by -1: LO = most-negative value (0x80000000 at 32 bits), HI = 0.
- i_start while busy is ignored. The in-flight op is not disturbed and no second op is queued.
- i_A, i_B and i_op are ignored outside the start cycle.
- HI/LO hold their values when no op completes.

## Timing
- Reset values: o_busy=0, o_done=0, o_hi=0, o_lo=0. FSM in IDLE, counter 0.
- i_reset has priority over everything. Asserted mid-operation, it aborts the op at that edge: HI/LO are cleared, no o_done pulse.
- Cycle numbering: i_start sampled high in IDLE at edge E0.
  - o_busy is high from after E0 through edge E0+DATA_SIZE+1.
  - At edge E0+DATA_SIZE+1 (the FINISH edge), HI/LO are updated, o_done goes high and o_busy goes low together.
  - o_done lasts exactly one cycle.
  - Total latency: DATA_SIZE+1 edges from the start edge to valid HI/LO (33 at 32 bits).
- Back-to-back: a new i_start is accepted in the cycle o_done is high. Maximum throughput is one op per DATA_SIZE+2 cycles.
- o_busy is registered, with no combinational path from i_start. The hazard unit decodes a pending mult/div itself for the start cycle.

## Configuration
- Macro: MDU_MTHILO_EN.
- Defined:
  - Ports i_hi_we, i_lo_we and i_wdata exist.
  - In IDLE, a write enable loads i_wdata into HI and/or LO at the next edge. Both enables may be high together.
  - A write in the same cycle as i_start is performed and the op starts normally; the op's result later overwrites HI/LO.
  - Writes while busy are ignored.
- Not defined: the ports are absent and HI/LO change only on reset or at FINISH.

## Test plan
- Reset mid-op: MULTU 5×7, then i_reset at cycle 10 -> o_busy=0, hi=lo=0, no o_done. Then MULTU 5×7 -> lo=35, hi=0, o_done exactly 33 edges after start.
- MULT 0xFFFFFFFF × 0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU of the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 7/2 -> lo=3, hi=1.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 9/0 -> lo=0xFFFFFFFF, hi=9, normal latency.
- Busy and back-to-back starts:
  - i_start held high throughout -> ops complete every 34 cycles.
  - A start pulse at cycle 5 of an op is ignored: one o_done only, HI/LO from the first op.
- MDU_MTHILO_EN: idle write hi=0xA5A5A5A5 -> o_hi updates next edge. The same write while busy -> no effect.
